// File: rtl/bytecode_fetch.sv
// Bytecode fetch unit: serialises opcode/argument and data-word byte reads
// over a single program-memory port and presents them to the cpu.
module bytecode_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic [15:0] dataindex,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  op_code,
  output logic [7:0]  arg1,
  output logic [7:0]  arg2,
  output logic [31:0] dataparams,
  output logic        ins_valid,
  output logic        data_valid
);

  typedef enum logic [3:0] {
    IDLE, I0, I1, I2, IW,
    D0, D1, D2, D3, DW
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic [7:0]  op_code_q, op_code_d;
  logic [7:0]  arg1_q, arg1_d;
  logic [7:0]  arg2_q, arg2_d;
  logic [31:0] dataparams_q, dataparams_d;
  logic        ins_valid_q, ins_valid_d;
  logic        data_valid_q, data_valid_d;
  logic        ins_ok_q, ins_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [15:0] fetched_pc_q, fetched_pc_d;
  logic [15:0] fetched_di_q, fetched_di_d;
  logic [15:0] pc_lat_q, pc_lat_d;
  logic [15:0] di_lat_q, di_lat_d;
  logic [7:0]  ibuf0_q, ibuf0_d;
  logic [7:0]  ibuf1_q, ibuf1_d;
  logic [23:0] dbuf_q, dbuf_d;

  logic ins_req;
  logic dat_req;
  logic i_abort;
  logic d_abort;

  always_comb begin
    ins_req = !ins_ok_q || (pc != fetched_pc_q);
    dat_req = !data_ok_q || (dataindex != fetched_di_q);
    i_abort = (pc != pc_lat_q);
    d_abort = ins_req || (dataindex != di_lat_q);

    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_rd_d     = 1'b0;
    op_code_d    = op_code_q;
    arg1_d       = arg1_q;
    arg2_d       = arg2_q;
    dataparams_d = dataparams_q;
    ins_valid_d  = ins_valid_q;
    data_valid_d = data_valid_q;
    ins_ok_d     = ins_ok_q;
    data_ok_d    = data_ok_q;
    fetched_pc_d = fetched_pc_q;
    fetched_di_d = fetched_di_q;
    pc_lat_d     = pc_lat_q;
    di_lat_d     = di_lat_q;
    ibuf0_d      = ibuf0_q;
    ibuf1_d      = ibuf1_q;
    dbuf_d       = dbuf_q;

    // Stale outputs are withdrawn as soon as the inputs move on;
    // a commit below overrides this.
    if (ins_req) begin
      ins_valid_d = 1'b0;
      op_code_d   = 8'h00;
    end
    if (dat_req) begin
      data_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ins_req) begin
          pc_lat_d   = pc;
          mem_addr_d = pc;
          mem_rd_d   = 1'b1;
          ins_ok_d   = 1'b0;
          state_d    = I0;
        end else if (dat_req) begin
          di_lat_d   = dataindex;
          mem_addr_d = {dataindex[13:0], 2'b00};
          mem_rd_d   = 1'b1;
          data_ok_d  = 1'b0;
          state_d    = D0;
        end
      end
      I0: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          mem_addr_d = pc_lat_q + 16'd1;
          mem_rd_d   = 1'b1;
          state_d    = I1;
        end
      end
      I1: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          ibuf0_d    = mem_rdata;
          mem_addr_d = pc_lat_q + 16'd2;
          mem_rd_d   = 1'b1;
          state_d    = I2;
        end
      end
      I2: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          ibuf1_d = mem_rdata;
          state_d = IW;
        end
      end
      IW: begin
        if (!i_abort) begin
          op_code_d    = ibuf0_q;
          arg1_d       = ibuf1_q;
          arg2_d       = mem_rdata;
          fetched_pc_d = pc_lat_q;
          ins_ok_d     = 1'b1;
          ins_valid_d  = 1'b1;
        end
        state_d = IDLE;
      end
      // Word base is 4-aligned, so the byte offsets never carry.
      D0: begin
        if (d_abort) begin
          state_d = IDLE;
        end else begin
          mem_addr_d = {di_lat_q[13:0], 2'b01};
          mem_rd_d   = 1'b1;
          state_d    = D1;
        end
      end
      D1: begin
        if (d_abort) begin
          state_d = IDLE;
        end else begin
          dbuf_d[23:16] = mem_rdata;
          mem_addr_d    = {di_lat_q[13:0], 2'b10};
          mem_rd_d      = 1'b1;
          state_d       = D2;
        end
      end
      D2: begin
        if (d_abort) begin
          state_d = IDLE;
        end else begin
          dbuf_d[15:8] = mem_rdata;
          mem_addr_d   = {di_lat_q[13:0], 2'b11};
          mem_rd_d     = 1'b1;
          state_d      = D3;
        end
      end
      D3: begin
        if (d_abort) begin
          state_d = IDLE;
        end else begin
          dbuf_d[7:0] = mem_rdata;
          state_d     = DW;
        end
      end
      DW: begin
        if (!d_abort) begin
          dataparams_d = {dbuf_q, mem_rdata};
          fetched_di_d = di_lat_q;
          data_ok_d    = 1'b1;
          data_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      op_code_q    <= '0;
      arg1_q       <= '0;
      arg2_q       <= '0;
      dataparams_q <= '0;
      ins_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      ins_ok_q     <= 1'b0;
      data_ok_q    <= 1'b0;
      fetched_pc_q <= '0;
      fetched_di_q <= '0;
      pc_lat_q     <= '0;
      di_lat_q     <= '0;
      ibuf0_q      <= '0;
      ibuf1_q      <= '0;
      dbuf_q       <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      op_code_q    <= op_code_d;
      arg1_q       <= arg1_d;
      arg2_q       <= arg2_d;
      dataparams_q <= dataparams_d;
      ins_valid_q  <= ins_valid_d;
      data_valid_q <= data_valid_d;
      ins_ok_q     <= ins_ok_d;
      data_ok_q    <= data_ok_d;
      fetched_pc_q <= fetched_pc_d;
      fetched_di_q <= fetched_di_d;
      pc_lat_q     <= pc_lat_d;
      di_lat_q     <= di_lat_d;
      ibuf0_q      <= ibuf0_d;
      ibuf1_q      <= ibuf1_d;
      dbuf_q       <= dbuf_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign op_code    = op_code_q;
  assign arg1       = arg1_q;
  assign arg2       = arg2_q;
  assign dataparams = dataparams_q;
  assign ins_valid  = ins_valid_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: byte-array memory with one-cycle read
// latency, directed scenarios plus randomized pc/dataindex traffic.
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0;
  logic [15:0] dataindex = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  op_code;
  logic [7:0]  arg1;
  logic [7:0]  arg2;
  logic [31:0] dataparams;
  logic        ins_valid;
  logic        data_valid;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_dp;

  bytecode_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .dataindex  (dataindex),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .op_code    (op_code),
    .arg1       (arg1),
    .arg2       (arg2),
    .dataparams (dataparams),
    .ins_valid  (ins_valid),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [7:0] byte_at(input logic [15:0] a);
    return mem[a];
  endfunction

  function automatic logic [31:0] word_at(input logic [15:0] di);
    logic [15:0] a;
    a = 16'(di * 4);
    return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ins(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ins_valid && n < max);
  endtask

  task automatic wait_data(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!data_valid && n < max);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 16'h0)
      $display("FAIL reset_mem: rd=%b addr=%h want 0/0000", mem_rd, mem_addr);
    else passed++;
    checks++;
    if (op_code !== 8'h00 || arg1 !== 8'h00 || arg2 !== 8'h00)
      $display("FAIL reset_ins: op=%h a1=%h a2=%h want 00", op_code, arg1, arg2);
    else passed++;
    checks++;
    if (dataparams !== 32'h0 || ins_valid !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL reset_data: dp=%h iv=%b dv=%b want 0",
               dataparams, ins_valid, data_valid);
    else passed++;
  endtask

  task automatic test_basic();
    int n, m;
    @(negedge clk);
    rst = 1'b0;
    wait_ins(20, n);
    checks++;
    if (n !== 5 || ins_valid !== 1'b1)
      $display("FAIL basic_ins_lat: got %0d cycles iv=%b want 5/1", n, ins_valid);
    else passed++;
    checks++;
    if (op_code !== 8'hB8 || arg1 !== 8'h00 || arg2 !== 8'h05)
      $display("FAIL basic_ins_val: got %h %h %h want b8 00 05", op_code, arg1, arg2);
    else passed++;
    checks++;
    if (data_valid !== 1'b0)
      $display("FAIL basic_data_early: dv=%b want 0", data_valid);
    else passed++;
    wait_data(30, m);
    checks++;
    if (n + m !== 11 || data_valid !== 1'b1)
      $display("FAIL basic_data_lat: got %0d cycles want 11", n + m);
    else passed++;
    checks++;
    if (dataparams !== 32'h12345678 || ins_valid !== 1'b1)
      $display("FAIL basic_data_val: dp=%h iv=%b want 12345678/1",
               dataparams, ins_valid);
    else passed++;
    tick();
    checks++;
    if (mem_rd !== 1'b0)
      $display("FAIL basic_idle_rd: rd=%b want 0", mem_rd);
    else passed++;
  endtask

  task automatic test_wrap();
    int n;
    @(negedge clk);
    mem[16'hFFFF] = 8'h10;
    mem[16'h0000] = 8'h07;
    mem[16'h0001] = 8'h2A;
    pc = 16'hFFFF;
    wait_ins(20, n);
    checks++;
    if (n !== 5 || op_code !== 8'h10 || arg1 !== 8'h07 || arg2 !== 8'h2A)
      $display("FAIL wrap: n=%0d got %h %h %h want 5 10 07 2a",
               n, op_code, arg1, arg2);
    else passed++;
    checks++;
    if (data_valid !== 1'b1 || dataparams !== 32'h12345678)
      $display("FAIL wrap_data_hold: dv=%b dp=%h want 1/12345678",
               data_valid, dataparams);
    else passed++;
  endtask

  task automatic test_abort();
    int n;
    bit bad;
    @(negedge clk);
    mem[16'h0010] = 8'hA1;
    mem[16'h0011] = 8'hA2;
    mem[16'h0012] = 8'hA3;
    mem[16'h0020] = 8'hC1;
    mem[16'h0021] = 8'hC2;
    mem[16'h0022] = 8'hC3;
    pc = 16'h0010;
    tick();
    tick();
    @(negedge clk);
    pc = 16'h0020;
    n = 0;
    bad = 0;
    do begin
      tick();
      n++;
      if (!ins_valid && op_code !== 8'h00) bad = 1;
      if (op_code === 8'hA1) bad = 1;
    end while (!ins_valid && n < 20);
    checks++;
    if (bad || ins_valid !== 1'b1)
      $display("FAIL abort_nop: bad=%0d iv=%b op=%h want clean 00 until commit",
               bad, ins_valid, op_code);
    else passed++;
    checks++;
    if (op_code !== 8'hC1 || arg1 !== 8'hC2 || arg2 !== 8'hC3)
      $display("FAIL abort_val: got %h %h %h want c1 c2 c3", op_code, arg1, arg2);
    else passed++;
  endtask

  task automatic test_both();
    int n, m;
    @(negedge clk);
    mem[16'h0040] = 8'h5A;
    mem[16'h0041] = 8'h6B;
    mem[16'h0042] = 8'h7C;
    mem[16'h0080] = 8'hDE;
    mem[16'h0081] = 8'hAD;
    mem[16'h0082] = 8'hBE;
    mem[16'h0083] = 8'hEF;
    mem[16'h0084] = 8'h01;
    mem[16'h0085] = 8'h23;
    mem[16'h0086] = 8'h45;
    mem[16'h0087] = 8'h67;
    pc = 16'h0040;
    dataindex = 16'h0020;
    wait_ins(20, n);
    checks++;
    if (n !== 5 || data_valid !== 1'b0 || op_code !== 8'h5A)
      $display("FAIL both_ins_first: n=%0d dv=%b op=%h want 5/0/5a",
               n, data_valid, op_code);
    else passed++;
    wait_data(30, m);
    checks++;
    if (n + m !== 11 || dataparams !== 32'hDEADBEEF)
      $display("FAIL both_data: n=%0d dp=%h want 11/deadbeef", n + m, dataparams);
    else passed++;
    @(negedge clk);
    dataindex = 16'h0021;
    tick();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 16'h0 || op_code !== 8'h0 ||
        arg1 !== 8'h0 || arg2 !== 8'h0 || dataparams !== 32'h0 ||
        ins_valid !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL midreset: rd=%b addr=%h op=%h a1=%h a2=%h dp=%h iv=%b dv=%b want 0",
               mem_rd, mem_addr, op_code, arg1, arg2, dataparams,
               ins_valid, data_valid);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    wait_ins(20, n);
    checks++;
    if (n !== 5 || op_code !== 8'h5A || arg1 !== 8'h6B || arg2 !== 8'h7C)
      $display("FAIL restart_ins: n=%0d got %h %h %h want 5 5a 6b 7c",
               n, op_code, arg1, arg2);
    else passed++;
    wait_data(30, m);
    checks++;
    if (n + m !== 11 || dataparams !== 32'h01234567)
      $display("FAIL restart_data: n=%0d dp=%h want 11/01234567", n + m, dataparams);
    else passed++;
    exp_dp = 32'h01234567;
  endtask

  task automatic test_random();
    int r, hold, k;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      r = $urandom_range(0, 3);
      if (r[0]) pc = 16'($urandom);
      if (r[1]) dataindex = 16'($urandom);
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        tick();
        checks++;
        if (ins_valid ? (op_code !== byte_at(pc) ||
                         arg1 !== byte_at(pc + 16'd1) ||
                         arg2 !== byte_at(pc + 16'd2))
                      : (op_code !== 8'h00))
          $display("FAIL rand_ins: pc=%h iv=%b got %h %h %h", pc,
                   ins_valid, op_code, arg1, arg2);
        else passed++;
        if (data_valid) exp_dp = word_at(dataindex);
        checks++;
        if (dataparams !== exp_dp)
          $display("FAIL rand_data: di=%h dv=%b got %h want %h", dataindex,
                   data_valid, dataparams, exp_dp);
        else passed++;
      end
      k = 0;
      while (!(ins_valid && data_valid) && k < 30) begin
        tick();
        k++;
      end
      checks++;
      if (!(ins_valid && data_valid) ||
          op_code !== byte_at(pc) || dataparams !== word_at(dataindex))
        $display("FAIL rand_settle: iv=%b dv=%b op=%h want %h dp=%h want %h",
                 ins_valid, data_valid, op_code, byte_at(pc),
                 dataparams, word_at(dataindex));
      else passed++;
      exp_dp = word_at(dataindex);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0000] = 8'hB8;
    mem[16'h0001] = 8'h00;
    mem[16'h0002] = 8'h05;
    mem[16'h000C] = 8'h12;
    mem[16'h000D] = 8'h34;
    mem[16'h000E] = 8'h56;
    mem[16'h000F] = 8'h78;
    pc = 16'h0000;
    dataindex = 16'h0003;
    exp_dp = 32'h0;
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_both();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
